// File: rtl/register_file_sb.sv
// ============================================================================
//  Module   : register_file_sb
//  Brief    : Integer register file with write-to-read forwarding and a
//             per-register pending scoreboard with a live pending count.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module register_file_sb #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [ADDR_W-1:0]   raddr1,
  input  logic [ADDR_W-1:0]   raddr2,
  output logic [XLEN-1:0]     rdata1,
  output logic [XLEN-1:0]     rdata2,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  output logic                busy1,
  output logic                busy2,
  output logic [ADDR_W:0]     pend_cnt
);

  localparam int              NREG       = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_ZERO_IDX = '0;
  localparam logic [ADDR_W:0] c_CNT_ZERO = '0;

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_pend;
  logic [ADDR_W:0] r_pend_cnt;

  logic            w_wr_en;
  logic            w_iss_en;
  logic            w_set_new;
  logic            w_clr_real;
  logic [NREG-1:0] w_pend_nxt;
  logic            w_fwd1;
  logic            w_fwd2;
  logic            w_iss_hit1;
  logic            w_iss_hit2;
  logic [XLEN-1:0] w_dat1;
  logic [XLEN-1:0] w_dat2;
  logic            w_busy1;
  logic            w_busy2;

  // Index 0 is hard-wired: neither writes nor issues may touch it.
  assign w_wr_en  = we && (waddr != c_ZERO_IDX);
  assign w_iss_en = iss_valid && (iss_rd != c_ZERO_IDX);

  // A same-index issue supersedes the retiring writeback, so no clear occurs.
  assign w_set_new  = w_iss_en && !r_pend[iss_rd];
  assign w_clr_real = w_wr_en && r_pend[waddr] && !(w_iss_en && (iss_rd == waddr));

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_en) begin
      w_pend_nxt[waddr] = 1'b0;
    end
    if (w_iss_en) begin
      w_pend_nxt[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_pend_cnt <= c_CNT_ZERO;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= r_pend_cnt
                    + {{ADDR_W{1'b0}}, w_set_new}
                    - {{ADDR_W{1'b0}}, w_clr_real};
    end
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_fwd1 = w_wr_en && (waddr == raddr1);
      assign w_fwd2 = w_wr_en && (waddr == raddr2);
    end else begin : g_no_bypass
      assign w_fwd1 = 1'b0;
      assign w_fwd2 = 1'b0;
    end
  endgenerate

  assign w_iss_hit1 = w_iss_en && (iss_rd == raddr1);
  assign w_iss_hit2 = w_iss_en && (iss_rd == raddr2);

  assign w_dat1 = w_fwd1 ? wdata : r_regs[raddr1];
  assign w_dat2 = w_fwd2 ? wdata : r_regs[raddr2];

  // A forwarded writeback resolves the hazard unless a new producer issues now.
  assign w_busy1 = r_pend[raddr1] && !(w_fwd1 && !w_iss_hit1);
  assign w_busy2 = r_pend[raddr2] && !(w_fwd2 && !w_iss_hit2);

  assign rdata1   = rst_n ? w_dat1 : '0;
  assign rdata2   = rst_n ? w_dat2 : '0;
  assign busy1    = rst_n && w_busy1;
  assign busy2    = rst_n && w_busy2;
  assign pend_cnt = r_pend_cnt;

endmodule

`default_nettype wire
